// File: rtl/task_clk_gate_ctrl_if.sv
// Host command port of the task clock gate controller: valid/ready with opcode and step argument.
interface task_clk_gate_ctrl_if #(
    parameter int STEP_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/task_clk_gate_ctrl.sv
// Run/halt/step controller producing the registered BUFGCE enable for the gated task clock.
// Halts with zero overshoot at a breakpoint by looking one count ahead.
module task_clk_gate_ctrl #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 16,
    parameter int HCNT_W = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_reset,
    input  logic [WIDTH-1:0]     count_out,
    input  logic [WIDTH-1:0]     breakpoint,
    input  logic                 bp_valid,
    task_clk_gate_ctrl_if.slave  cmd,
    output logic                 task_clk_en,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [HCNT_W-1:0]    halt_count
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_e;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_HALT  = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_HOST = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_STEP = 2'b11;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        cause_q, cause_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              halted_q, halted_d;
    logic              accept;
    logic              hit;
    logic              enter_halt;

    assign accept = cmd.cmd_valid && ready_q;
    // Comparing against count_out+1 lets the enable drop on the same edge the counter reaches the breakpoint.
    assign hit    = en_q && bp_valid && ((count_out + WIDTH'(1)) == breakpoint);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cause_d    = cause_q;
        hcnt_d     = hcnt_q;
        enter_halt = 1'b0;

        if (accept && (cmd.cmd_op == OP_CLEAR)) begin
            hcnt_d  = '0;
            cause_d = CAUSE_NONE;
        end

        case (state_q)
            S_HALT: begin
                if (accept && (cmd.cmd_op == OP_RUN)) begin
                    state_d = S_RUN;
                end else if (accept && (cmd.cmd_op == OP_STEP)) begin
                    state_d = S_STEP;
                    step_d  = (cmd.cmd_arg == '0) ? '0 : (cmd.cmd_arg - STEP_W'(1));
                end
            end
            S_RUN: begin
                if (hit) begin
                    state_d    = S_HALT;
                    cause_d    = CAUSE_BP;
                    enter_halt = 1'b1;
                end else if (accept && (cmd.cmd_op == OP_HALT)) begin
                    state_d    = S_HALT;
                    cause_d    = CAUSE_HOST;
                    enter_halt = 1'b1;
                end
            end
            S_STEP: begin
                if (hit) begin
                    state_d    = S_HALT;
                    cause_d    = CAUSE_BP;
                    enter_halt = 1'b1;
                end else if (step_q == '0) begin
                    state_d    = S_HALT;
                    cause_d    = CAUSE_STEP;
                    enter_halt = 1'b1;
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (enter_halt && (hcnt_d != '1)) begin
            hcnt_d = hcnt_d + HCNT_W'(1);
        end

        en_d     = (state_d != S_HALT);
        ready_d  = (state_d != S_STEP);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q  <= S_HALT;
            step_q   <= '0;
            cause_q  <= CAUSE_NONE;
            hcnt_q   <= '0;
            en_q     <= 1'b0;
            ready_q  <= 1'b1;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cause_q  <= cause_d;
            hcnt_q   <= hcnt_d;
            en_q     <= en_d;
            ready_q  <= ready_d;
            halted_q <= halted_d;
        end
    end

    assign task_clk_en   = en_q;
    assign halted        = halted_q;
    assign halt_cause    = cause_q;
    assign halt_count    = hcnt_q;
    assign cmd.cmd_ready = ready_q;

endmodule
